// File: rtl/vram_arbiter_pkg.sv
// vram_arbiter_pkg: VGA timing and tile-map constants shared by the arbiter slice
package vram_arbiter_pkg;
  localparam int H_DISPLAY  = 640;
  localparam int V_DISPLAY  = 480;
  localparam int H_TOTAL    = 800;
  localparam int V_TOTAL    = 525;
  localparam int TILE_COLS  = 40;
  localparam int TILE_ROWS  = 30;
  localparam int TILE_SHIFT = 4;
  localparam int TILE_COUNT = TILE_COLS * TILE_ROWS;
  localparam int LOOKAHEAD  = 3;
endpackage

// File: rtl/vram_fetch_addr.sv
// vram_fetch_addr: lookahead position, display-slot flag and tile address for the next fetch
module vram_fetch_addr
  import vram_arbiter_pkg::*;
#(
  parameter int ADDR_W = 11
) (
  input  logic [9:0]        h_i,
  input  logic [9:0]        v_i,
  output logic              slot_o,
  output logic [ADDR_W-1:0] addr_o
);
  logic [10:0] hs, nh;
  logic [9:0]  nv;
  logic        wrap;
  logic [4:0]  r;
  logic [5:0]  c;
  assign hs     = {1'b0, h_i} + 11'(LOOKAHEAD);
  assign wrap   = hs >= 11'(H_TOTAL);
  assign nh     = wrap ? hs - 11'(H_TOTAL) : hs;
  assign nv     = wrap ? (v_i == 10'(V_TOTAL - 1) ? 10'd0 : v_i + 10'd1) : v_i;
  assign slot_o = h_i < 10'(H_TOTAL) && v_i < 10'(V_TOTAL) && nh < 11'(H_DISPLAY) &&
                  nv < 10'(V_DISPLAY) && nh[3:0] == 4'd0;
  assign r      = nv[8:TILE_SHIFT];
  assign c      = nh[9:TILE_SHIFT];
  // row*40 as row*32 + row*8
  assign addr_o = ADDR_W'({r, 5'b0}) + ADDR_W'({r, 3'b0}) + ADDR_W'(c);
endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the tile RAM between display prefetch and game-logic writes
module vram_arbiter
  import vram_arbiter_pkg::*;
#(
  parameter int ADDR_W        = 11,
  parameter int DATA_W        = 4,
  parameter int ACTIVE_WRITES = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [9:0]        h_count,
  input  logic [9:0]        v_count,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              wr_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] tile_code,
  output logic              frame_tick
);
  logic              slot, blank, accept, inrange;
  logic [ADDR_W-1:0] fetch_addr;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d, tile_q, tile_d;
  logic              ram_we_q, ram_we_d, wr_err_q, wr_err_d, tick_q, tick_d;
  logic              f1_q, f2_q;
  vram_fetch_addr #(.ADDR_W(ADDR_W)) u_fetch (
    .h_i   (h_count),
    .v_i   (v_count),
    .slot_o(slot),
    .addr_o(fetch_addr)
  );
  assign blank    = h_count >= 10'(H_DISPLAY) || v_count >= 10'(V_DISPLAY);
  assign wr_ready = !RST && !slot && (ACTIVE_WRITES != 0 || blank);
  assign accept   = wr_valid && wr_ready;
  assign inrange  = wr_addr < ADDR_W'(TILE_COUNT);
  always_comb begin
    ram_addr_d  = slot ? fetch_addr : (accept && inrange) ? wr_addr : ram_addr_q;
    ram_we_d    = accept && inrange;
    ram_wdata_d = (accept && inrange) ? wr_data : ram_wdata_q;
    wr_err_d    = accept && !inrange;
    tile_d      = f2_q ? ram_rdata : tile_q;
    tick_d      = h_count == 10'd0 && v_count == 10'(V_DISPLAY);
  end
  // f1/f2 track a fetch through the RAM's address and read-data cycles
  always_ff @(posedge CLK) begin
    if (RST) begin
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
      wr_err_q    <= 1'b0;
      tile_q      <= '0;
      tick_q      <= 1'b0;
      f1_q        <= 1'b0;
      f2_q        <= 1'b0;
    end else begin
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
      wr_err_q    <= wr_err_d;
      tile_q      <= tile_d;
      tick_q      <= tick_d;
      f1_q        <= slot;
      f2_q        <= f1_q;
    end
  end
  assign ram_addr   = ram_addr_q;
  assign ram_we     = ram_we_q;
  assign ram_wdata  = ram_wdata_q;
  assign wr_err     = wr_err_q;
  assign tile_code  = tile_q;
  assign frame_tick = tick_q;
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed checks of fetch timing, write arbitration, errors, frame tick and reset
module tb_vram_arbiter;
  logic        CLK = 1'b0, RST = 1'b1;
  logic [9:0]  h_count = '0, v_count = '0;
  logic        wr_valid = 1'b0;
  logic [10:0] wr_addr = '0;
  logic [3:0]  wr_data = '0;
  logic        rdy1, err1, we1, tick1, rdy2, err2, we2, tick2;
  logic [10:0] a1, a2;
  logic [3:0]  wd1, tc1, rd1, wd2, tc2;
  int          total = 0, bad = 0;
  vram_arbiter #(.ACTIVE_WRITES(1)) u1 (
    .CLK(CLK), .RST(RST), .h_count(h_count), .v_count(v_count),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(rdy1), .wr_err(err1), .ram_addr(a1), .ram_we(we1), .ram_wdata(wd1),
    .ram_rdata(rd1), .tile_code(tc1), .frame_tick(tick1)
  );
  vram_arbiter #(.ACTIVE_WRITES(0)) u2 (
    .CLK(CLK), .RST(RST), .h_count(h_count), .v_count(v_count),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(rdy2), .wr_err(err2), .ram_addr(a2), .ram_we(we2), .ram_wdata(wd2),
    .ram_rdata(4'h0), .tile_code(tc2), .frame_tick(tick2)
  );
  always #5 CLK = ~CLK;
  // model RAM: tile 82 holds 4'hA, every other tile holds its low address nibble
  always @(posedge CLK) rd1 <= (a1 == 11'd82) ? 4'hA : a1[3:0];
  task check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task set(input int h, input int v);
    h_count = 10'(h);
    v_count = 10'(v);
    #1;
  endtask
  task tick;
    @(posedge CLK);
    #1;
  endtask
  initial begin
    wr_valid = 1'b1; wr_addr = 11'd5; wr_data = 4'd2;
    set(300, 200);
    check("rst_ready", rdy1, 0);
    tick; tick;
    check("rst_addr", a1, 0); check("rst_we", we1, 0); check("rst_wdata", wd1, 0);
    check("rst_tile", tc1, 0); check("rst_err", err1, 0); check("rst_tick", tick1, 0);
    RST = 1'b0; wr_valid = 1'b0;
    set(29, 35); check("slot_ready", rdy1, 0); tick;
    check("fetch_addr82", a1, 82); check("fetch_we", we1, 0);
    set(30, 35); tick;
    set(31, 35); check("tile_before", tc1, 0); tick;
    for (int h = 32; h < 48; h++) begin
      set(h, 35); check("tile_hold", tc1, 4'hA); tick;
    end
    set(48, 35); check("tile_next", tc1, 4'h3);
    set(797, 0); check("wrap_slot", rdy1, 0); tick; check("wrap_addr0", a1, 0);
    set(621, 479); tick; check("last_addr", a1, 1199);
    set(637, 479); check("noslot_637", rdy1, 1); tick;
    check("noslot_hold", a1, 1199); check("noslot_we", we1, 0);
    set(797, 479); check("noslot_797", rdy1, 1); tick;
    wr_valid = 1'b1; wr_addr = 11'd5; wr_data = 4'd3;
    set(13, 0); check("wr_slot_ready", rdy1, 0); tick;
    check("wr_slot_addr", a1, 1); check("wr_slot_we", we1, 0);
    set(14, 0); check("wr_ready14", rdy1, 1); check("aw0_active", rdy2, 0); tick;
    check("wr_we", we1, 1); check("wr_addr", a1, 5); check("wr_data", wd1, 3); check("aw0_we", we2, 0);
    wr_addr = 11'd7; wr_data = 4'd9;
    set(100, 10); check("aw0_h100", rdy2, 0); tick;
    set(639, 10); check("aw0_h639", rdy2, 0); tick;
    set(640, 10); check("aw0_h640", rdy2, 1); tick;
    check("aw0_we641", we2, 1); check("aw0_addr", a2, 7); check("aw0_data", wd2, 9);
    wr_valid = 1'b0;
    set(641, 10); tick; check("aw0_we_off", we2, 0);
    wr_valid = 1'b1; wr_addr = 11'd1300;
    set(700, 100); check("err_ready", rdy1, 1); tick;
    check("err_we", we1, 0); check("err_pulse", err1, 1);
    wr_valid = 1'b0;
    set(701, 100); tick; check("err_clear", err1, 0);
    set(0, 479); tick; check("tick_479", tick1, 0);
    set(0, 480); tick; check("tick_480", tick1, 1);
    set(1, 480); tick; check("tick_once", tick1, 0);
    set(0, 481); tick; check("tick_481", tick1, 0);
    wr_valid = 1'b1; wr_addr = 11'd5; wr_data = 4'd2;
    set(301, 200); tick; check("pre_rst_addr", a1, 499);
    RST = 1'b1;
    set(302, 200); check("mid_rst_ready", rdy1, 0); tick;
    check("mid_rst_addr", a1, 0); check("mid_rst_we", we1, 0); check("mid_rst_tile", tc1, 0);
    RST = 1'b0; wr_valid = 1'b0;
    set(303, 200); tick;
    set(304, 200); check("abandoned", tc1, 0); tick;
    set(317, 200); tick; check("resume_addr", a1, 500);
    set(318, 200); tick;
    set(319, 200); tick;
    set(320, 200); check("resume_tile", tc1, 4'h4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
